// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master slice.
//   - SPI_DATA_W / SPI_LEN_W / SPI_DIV_W : default widths (max transfer bits,
//     length field width = log2(SPI_DATA_W), half-period divider width)
//   - spiState_e : transfer sequencer states
//   - lenMask()  : turns an effective bit count into a right-aligned mask
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_DATA_W = 64;
  localparam int SPI_LEN_W  = 6;
  localparam int SPI_DIV_W  = 8;

  // IDLE  : waiting for a request, bus parked (ss=1, sck=0, mosi=1)
  // LEAD  : select asserted, first bit on mosi, sck low for one half period
  // HIGH  : sck high for one half period (slave samples on the rise)
  // LOW   : sck low between bits, next bit already on mosi
  // TRAIL : select still low for one half period after the last fall
  // DONE  : response presented until the consumer takes it
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    TRAIL = 3'd4,
    DONE  = 3'd5
  } spiState_e;

  // Mask with the low n bits set. n is the effective length (1..SPI_DATA_W),
  // so n == SPI_DATA_W yields all ones without any shift overflow.
  function automatic logic [SPI_DATA_W-1:0] lenMask(input logic [SPI_LEN_W:0] n);
    logic [SPI_DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < SPI_DATA_W; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

endpackage

// File: rtl/spi_clkdiv.sv
// ---------------------------------------------------------------------------
// spi_clkdiv
// Half-period counter for the SPI master. Counts 0..div_i while enabled and
// flags the last cycle of the current phase with tick_o. The counter restarts
// from zero whenever the sequencer changes phase (load_i) or is idle.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   en_i         : a timed phase (LEAD/HIGH/LOW/TRAIL) is in progress
//   load_i       : phase change this cycle, restart the count
//   div_i        : latched divider, phase length is div_i+1 cycles
//   tick_o       : current cycle is the last one of the phase
// ---------------------------------------------------------------------------
module spi_clkdiv
  import spi_pkg::*;
#(
  parameter int DIV_W = SPI_DIV_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // The count is parked at zero outside timed phases so that the first
  // phase after a handshake is already aligned without an explicit load.
  always_comb begin
    cnt_d  = cnt_q;
    tick_o = en_i && (cnt_q == div_i);
    if (!en_i || load_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master
// Single chip-select SPI master, sck idle low. mosi changes while sck is low,
// the slave samples on the sck rise, miso is captured as sck falls.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready only while idle)
//   req_len      : bit count, 0 means DATA_W bits
//   req_div      : half period is req_div+1 clocks
//   req_tx       : transmit word, bit len-1 goes out first
//   resp_valid/resp_ready : response handshake
//   resp_rx      : received bits right-aligned, zero above len
//   sck, ss, mosi : registered SPI outputs (ss active low)
//   miso         : serial input from the slave
// ---------------------------------------------------------------------------
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int LEN_W  = SPI_LEN_W,
  parameter int DIV_W  = SPI_DIV_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DIV_W-1:0]  req_div,
  input  logic [DATA_W-1:0] req_tx,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rx,
  output logic              sck,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);

  spiState_e         state_q, state_d;
  logic              sck_q, sck_d;
  logic              ss_q, ss_d;
  logic              mosi_q, mosi_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] respRx_q, respRx_d;
  logic [LEN_W:0]    bitCnt_q, bitCnt_d;
  logic [LEN_W:0]    len_q, len_d;
  logic [DIV_W-1:0]  div_q, div_d;

  logic              phaseTick;
  logic              phaseActive;
  logic              phaseLoad;
  logic [LEN_W:0]    bitCntInc;
  logic [LEN_W:0]    reqLenEff;
  logic [DATA_W-1:0] txAligned;

  assign phaseActive = (state_q == LEAD) || (state_q == HIGH) ||
                       (state_q == LOW)  || (state_q == TRAIL);
  assign phaseLoad   = (state_d != state_q);

  spi_clkdiv #(
    .DIV_W (DIV_W)
  ) uClkdiv (
    .clock  (clock),
    .reset  (reset),
    .en_i   (phaseActive),
    .load_i (phaseLoad),
    .div_i  (div_q),
    .tick_o (phaseTick)
  );

  // Sequencer and next values of every SPI output flop. The transmit word is
  // left-aligned at the handshake so the outgoing bit is always the MSB of
  // tx_q, which avoids a variable bit select on every shift.
  always_comb begin
    state_d  = state_q;
    sck_d    = sck_q;
    ss_d     = ss_q;
    mosi_d   = mosi_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    respRx_d = respRx_q;
    bitCnt_d = bitCnt_q;
    len_d    = len_q;
    div_d    = div_q;

    bitCntInc = bitCnt_q + (LEN_W+1)'(1);
    reqLenEff = (req_len == '0) ? (LEN_W+1)'(DATA_W) : {1'b0, req_len};
    txAligned = req_tx << ((LEN_W+1)'(DATA_W) - reqLenEff);

    unique case (state_q)
      IDLE: begin
        ss_d   = 1'b1;
        sck_d  = 1'b0;
        mosi_d = 1'b1;
        if (req_valid) begin
          state_d  = LEAD;
          len_d    = reqLenEff;
          div_d    = req_div;
          ss_d     = 1'b0;
          mosi_d   = txAligned[DATA_W-1];
          tx_d     = txAligned << 1;
          rx_d     = '0;
          bitCnt_d = '0;
        end
      end
      LEAD, LOW: begin
        if (phaseTick) begin
          state_d = HIGH;
          sck_d   = 1'b1;
        end
      end
      HIGH: begin
        // The falling edge is where miso is taken and, unless this was the
        // last bit, where mosi moves on to the next bit.
        if (phaseTick) begin
          sck_d    = 1'b0;
          rx_d     = {rx_q[DATA_W-2:0], miso};
          bitCnt_d = bitCntInc;
          if (bitCntInc == len_q) begin
            state_d = TRAIL;
          end else begin
            state_d = LOW;
            mosi_d  = tx_q[DATA_W-1];
            tx_d    = tx_q << 1;
          end
        end
      end
      TRAIL: begin
        if (phaseTick) begin
          state_d  = DONE;
          ss_d     = 1'b1;
          mosi_d   = 1'b1;
          respRx_d = rx_q & DATA_W'(lenMask((SPI_LEN_W+1)'(len_q)));
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ss_d    = 1'b1;
        sck_d   = 1'b0;
        mosi_d  = 1'b1;
      end
    endcase
  end

  // Reset parks the bus immediately and drops any transfer in flight, so an
  // aborted transfer never reaches DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      sck_q    <= 1'b0;
      ss_q     <= 1'b1;
      mosi_q   <= 1'b1;
      tx_q     <= '0;
      rx_q     <= '0;
      respRx_q <= '0;
      bitCnt_q <= '0;
      len_q    <= '0;
      div_q    <= '0;
    end else begin
      state_q  <= state_d;
      sck_q    <= sck_d;
      ss_q     <= ss_d;
      mosi_q   <= mosi_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      respRx_q <= respRx_d;
      bitCnt_q <= bitCnt_d;
      len_q    <= len_d;
      div_q    <= div_d;
    end
  end

  assign sck        = sck_q;
  assign ss         = ss_q;
  assign mosi       = mosi_q;
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign resp_rx    = respRx_q;

endmodule

// File: tb/tb_spi_master.sv
// ---------------------------------------------------------------------------
// tb_spi_master
// Directed bench for spi_master. A transfer-level model predicts, from the
// handshake cycle, H and len, what ss/sck/mosi/req_ready/resp_valid/resp_rx
// must be on every cycle; a compare process checks the DUT against it. miso
// comes either from a loopback of mosi or from an echo slave that answers
// ones for the first byte and then replays what it received.
// ---------------------------------------------------------------------------
module tb_spi_master;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_len;
  logic [7:0]  req_div;
  logic [63:0] req_tx;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rx;
  logic        sck;
  logic        ss;
  logic        mosi;
  logic        miso;

  int vectors;
  int miscompares;

  bit echoMode;
  bit cmpEn;

  spi_master dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_len    (req_len),
    .req_div    (req_div),
    .req_tx     (req_tx),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rx    (resp_rx),
    .sck        (sck),
    .ss         (ss),
    .mosi       (mosi),
    .miso       (miso)
  );

  always #5 clock = ~clock;

  // Echo slave: samples mosi on each sck rise, answers 1 for the first eight
  // bits and afterwards replays the received bits in order.
  logic sBits [0:63];
  int   sCnt;
  logic echoBit;

  always @(posedge sck or posedge ss) begin
    if (ss === 1'b1) begin
      sCnt = 0;
    end else if (sCnt < 64) begin
      sBits[sCnt] = mosi;
      sCnt = sCnt + 1;
    end
  end

  always_comb begin
    echoBit = 1'b1;
    if (sCnt > 8) echoBit = sBits[sCnt-9];
  end

  assign miso = echoMode ? echoBit : mosi;

  // Expected received word: bit k of the serial stream (k=0 first) lands at
  // position len-1-k of the right-aligned result.
  function automatic logic [63:0] modelRx(input bit echo, input logic [63:0] tx, input int len);
    logic [63:0] r;
    logic        b;
    r = '0;
    for (int k = 0; k < len; k++) begin
      if (echo) b = (k < 8) ? 1'b1 : tx[len-1-(k-8)];
      else      b = tx[len-1-k];
      r[len-1-k] = b;
    end
    return r;
  endfunction

  // Transfer-level model, advanced on every clock edge.
  int          cyc;
  bit          mActive;
  int          mT0, mH, mL;
  logic [63:0] mTx;
  logic [63:0] mRx;
  int          lastRespHs;

  always @(posedge clock) begin
    if (reset) begin
      mActive = 1'b0;
    end else if (!mActive && req_valid) begin
      mActive = 1'b1;
      mT0     = cyc;
      mH      = int'(req_div) + 1;
      mL      = (req_len == 6'd0) ? 64 : int'(req_len);
      mTx     = req_tx;
      mRx     = modelRx(echoMode, req_tx, mL);
    end else if (mActive && (cyc - mT0) >= mH*(2*mL+1)+1 && resp_ready) begin
      mActive    = 1'b0;
      lastRespHs = cyc;
    end
    cyc = cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, plus measurements of the waveform
  // (ss-low length, sck rises, phase run lengths, response latency).
  int   seenT0;
  int   ssLow, rises, hiRun, loRun, hiMin, hiMax, loMin, loMax, respAt;
  bit   respSeen;
  logic prevSck;
  int   c, ssEnd, b, p;
  logic eSs, eSck, eMosi, eValid, eReady;

  always @(negedge clock) begin
    if (cmpEn) begin
      if (mActive && mT0 != seenT0) begin
        seenT0 = mT0;
        ssLow = 0; rises = 0; hiRun = 0; loRun = 0;
        hiMin = 1000000; hiMax = 0; loMin = 1000000; loMax = 0;
        respAt = -1; respSeen = 1'b0;
      end
      if (mActive) begin
        c      = cyc - mT0;
        ssEnd  = mH*(2*mL+1);
        eReady = 1'b0;
        if (c <= ssEnd) begin
          p      = (c-1)/mH;
          b      = (c-1)/(2*mH);
          if (b > mL-1) b = mL-1;
          eSs    = 1'b0;
          eSck   = (p % 2) == 1;
          eMosi  = mTx[mL-1-b];
          eValid = 1'b0;
        end else begin
          eSs = 1'b1; eSck = 1'b0; eMosi = 1'b1; eValid = 1'b1;
        end
      end else begin
        eSs = 1'b1; eSck = 1'b0; eMosi = 1'b1; eValid = 1'b0; eReady = 1'b1;
      end
      checkOutput("ss", ss, eSs);
      checkOutput("sck", sck, eSck);
      checkOutput("mosi", mosi, eMosi);
      checkOutput("req_ready", req_ready, eReady);
      checkOutput("resp_valid", resp_valid, eValid);
      if (eValid) checkOutput("resp_rx", resp_rx, mRx);

      if (ss === 1'b0) ssLow = ssLow + 1;
      if (sck === 1'b1 && prevSck === 1'b0) rises = rises + 1;
      if (sck === 1'b1) begin
        hiRun = hiRun + 1;
      end else if (hiRun > 0) begin
        if (hiRun < hiMin) hiMin = hiRun;
        if (hiRun > hiMax) hiMax = hiRun;
        hiRun = 0;
      end
      if (ss === 1'b0 && sck === 1'b0) begin
        loRun = loRun + 1;
      end else if (loRun > 0) begin
        if (loRun < loMin) loMin = loRun;
        if (loRun > loMax) loMax = loRun;
        loRun = 0;
      end
      prevSck = sck;
      if (resp_valid === 1'b1 && !respSeen) begin
        respSeen = 1'b1;
        respAt   = cyc - mT0;
      end
    end
  end

  // Present one request and return on the first cycle after its handshake;
  // the request fields are scrambled afterwards since they must be ignored.
  task automatic applyStimulus(input int len, input int div, input logic [63:0] tx, input bit echo);
    int n;
    @(negedge clock);
    echoMode  = echo;
    req_len   = 6'(len);
    req_div   = 8'(div);
    req_tx    = tx;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (req_ready !== 1'b1) checkOutput("req_accept_timeout", 64'(req_ready), 64'd1);
    @(negedge clock);
    req_valid = 1'b0;
    req_len   = 6'h2A;
    req_div   = 8'h11;
    req_tx    = ~tx;
  endtask

  task automatic waitResp(input int maxCyc, input logic [63:0] expRx, input string name);
    int n;
    n = 0;
    while (resp_valid !== 1'b1 && n < maxCyc) begin
      @(negedge clock);
      n++;
    end
    if (resp_valid !== 1'b1) checkOutput({name, "_timeout"}, 64'(resp_valid), 64'd1);
    else                     checkOutput(name, resp_rx, expRx);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    clock = 1'b0; reset = 1'b1; req_valid = 1'b0; req_len = '0; req_div = '0;
    req_tx = '0; resp_ready = 1'b1; echoMode = 1'b0; cmpEn = 1'b0;
    vectors = 0; miscompares = 0; cyc = 0; mActive = 1'b0; mT0 = -1; seenT0 = -1;
    lastRespHs = 0; prevSck = 1'b0; respSeen = 1'b0; respAt = -1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    cmpEn = 1'b1;
    $display("[TB] reset state");
    checkOutput("rst_ss", 64'(ss), 64'd1);
    checkOutput("rst_sck", 64'(sck), 64'd0);
    checkOutput("rst_mosi", 64'(mosi), 64'd1);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst_resp_rx", resp_rx, 64'd0);

    $display("[TB] loopback len=8 div=0");
    applyStimulus(8, 0, 64'h0000_0000_0000_00A5, 1'b0);
    waitResp(100, 64'h0000_0000_0000_00A5, "t1_rx");
    @(negedge clock);
    checkOutput("t1_ss_low", 64'(ssLow), 64'd17);
    checkOutput("t1_rises", 64'(rises), 64'd8);
    checkOutput("t1_resp_at", 64'(respAt), 64'd18);

    $display("[TB] echo slave len=16 div=3");
    applyStimulus(16, 3, 64'h0000_0000_0000_3500, 1'b1);
    checkOutput("t2_model_rx", mRx, 64'h0000_0000_0000_FF35);
    waitResp(300, 64'h0000_0000_0000_FF35, "t2_rx");
    @(negedge clock);
    checkOutput("t2_hi_min", 64'(hiMin), 64'd4);
    checkOutput("t2_hi_max", 64'(hiMax), 64'd4);
    checkOutput("t2_lo_min", 64'(loMin), 64'd4);
    checkOutput("t2_lo_max", 64'(loMax), 64'd4);
    checkOutput("t2_ss_low", 64'(ssLow), 64'd132);

    $display("[TB] loopback len=0 (64 bits)");
    applyStimulus(0, 0, 64'h8000_0000_0000_0001, 1'b0);
    waitResp(300, 64'h8000_0000_0000_0001, "t3_rx");
    @(negedge clock);
    checkOutput("t3_rises", 64'(rises), 64'd64);
    checkOutput("t3_ss_low", 64'(ssLow), 64'd129);

    $display("[TB] response backpressure");
    resp_ready = 1'b0;
    applyStimulus(8, 1, 64'h0000_0000_0000_003C, 1'b0);
    waitResp(100, 64'h0000_0000_0000_003C, "t4_rx");
    req_len = 6'd8; req_div = 8'd0; req_tx = 64'h0000_0000_0000_00C3; req_valid = 1'b1;
    repeat (10) begin
      @(negedge clock);
      checkOutput("t4_req_ready_low", 64'(req_ready), 64'd0);
      checkOutput("t4_rx_hold", resp_rx, 64'h0000_0000_0000_003C);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    checkOutput("t4_accept_gap", 64'(mT0 - lastRespHs), 64'd1);
    waitResp(100, 64'h0000_0000_0000_00C3, "t4_second_rx");

    $display("[TB] reset mid-transfer");
    applyStimulus(8, 2, 64'h0000_0000_0000_00F0, 1'b0);
    n = 0;
    while (rises < 3 && n < 200) begin
      @(posedge clock);
      n++;
    end
    if (rises < 3) checkOutput("t5_rise_timeout", 64'(rises), 64'd3);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("t5_ss", 64'(ss), 64'd1);
    checkOutput("t5_sck", 64'(sck), 64'd0);
    checkOutput("t5_mosi", 64'(mosi), 64'd1);
    checkOutput("t5_req_ready", 64'(req_ready), 64'd1);
    checkOutput("t5_resp_valid", 64'(resp_valid), 64'd0);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    checkOutput("t5_no_resp", 64'(respSeen), 64'd0);
    applyStimulus(8, 0, 64'h0000_0000_0000_005A, 1'b0);
    waitResp(100, 64'h0000_0000_0000_005A, "t5_after_rx");
    @(negedge clock);
    checkOutput("t5_after_ss_low", 64'(ssLow), 64'd17);

    $display("[TB] slowest divider div=255 len=1");
    applyStimulus(1, 255, 64'h0000_0000_0000_0001, 1'b0);
    waitResp(1000, 64'h0000_0000_0000_0001, "t6_rx");
    @(negedge clock);
    checkOutput("t6_hi_len", 64'(hiMax), 64'd256);
    checkOutput("t6_hi_min", 64'(hiMin), 64'd256);
    checkOutput("t6_rises", 64'(rises), 64'd1);
    checkOutput("t6_ss_low", 64'(ssLow), 64'd768);

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
